// File: rtl/logic_clock_domain_crossing_pkg.sv
// Constants shared by the write and read sides of the generic clock-domain-crossing FIFO.
package logic_clock_domain_crossing_pkg;

    localparam int ALMOST_FULL       = 4;
    localparam int ALMOST_EMPTY      = 2;
    localparam int MIN_ADDRESS_WIDTH = 3;

    // Largest occupancy at which the write side may still raise ready; the margin
    // absorbs the writes already in flight through the registered feedback path.
    function automatic int ready_threshold(input int address_width);
        return (1 << address_width) - 1 - ALMOST_FULL;
    endfunction

endpackage

// File: rtl/logic_clock_domain_crossing_generic_write.sv
// Write side of the generic CDC FIFO: registered write stage, binary write pointer and
// occupancy-based throttling against the read pointer synchronized into rx_aclk.
module logic_clock_domain_crossing_generic_write
    import logic_clock_domain_crossing_pkg::*;
#(
    parameter int DATA_WIDTH    = 1,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                     rx_aclk,
    input  logic                     rx_reset,
    input  logic                     rx_tvalid,
    input  logic [DATA_WIDTH-1:0]    rx_tdata,
    output logic                     rx_tready,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_pointer,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_pointer_synced
);

    localparam logic [ADDRESS_WIDTH-1:0] READY_LIMIT =
        ADDRESS_WIDTH'(ready_threshold(ADDRESS_WIDTH));

    generate
        if (ADDRESS_WIDTH < MIN_ADDRESS_WIDTH) begin : g_drc_address_width
            $error("ADDRESS_WIDTH must be at least %0d", MIN_ADDRESS_WIDTH);
        end
    endgenerate

    logic                     r_tready;
    logic                     r_write_enable;
    logic [ADDRESS_WIDTH-1:0] r_write_pointer;
    logic [ADDRESS_WIDTH-1:0] r_difference;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic                     w_accept;

    assign w_accept = rx_tvalid && r_tready;

    // Occupancy is modulo 2^ADDRESS_WIDTH; capacity stops one short so full never aliases empty.
    always_ff @(posedge rx_aclk) begin
        if (rx_reset) begin
            r_tready        <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_pointer <= '0;
            r_difference    <= '0;
        end else begin
            r_write_enable <= w_accept;
            if (r_write_enable) begin
                r_write_pointer <= r_write_pointer + ADDRESS_WIDTH'(1);
            end
            r_difference <= r_write_pointer - read_pointer_synced;
            r_tready     <= (r_difference <= READY_LIMIT);
        end
    end

    always_ff @(posedge rx_aclk) begin
        if (w_accept) begin
            r_write_data <= rx_tdata;
        end
    end

    assign rx_tready     = r_tready;
    assign write_enable  = r_write_enable;
    assign write_pointer = r_write_pointer;
    assign write_data    = r_write_data;

`ifdef OVL_ASSERT_ON
    a_no_overflow : assert property (@(posedge rx_aclk) disable iff (rx_reset)
        (r_difference == '1) |=> (r_difference != '0))
        else $error("write-side occupancy overflowed");

    a_no_underflow : assert property (@(posedge rx_aclk) disable iff (rx_reset)
        (r_difference == '0) |=> (r_difference != '1))
        else $error("write-side occupancy underflowed");
`endif

endmodule

// File: tb/tb_logic_clock_domain_crossing_generic_write.sv
// Self-checking bench for the CDC FIFO write side: cycle-history model plus directed scenarios.
module tb_logic_clock_domain_crossing_generic_write;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rx_reset;
    logic          rx_tvalid;
    logic [DW-1:0] rx_tdata;
    logic          rx_tready;
    logic          write_enable;
    logic [AW-1:0] write_pointer;
    logic [DW-1:0] write_data;
    logic [AW-1:0] rps;

    always #5 clk = ~clk;

    logic_clock_domain_crossing_generic_write #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .rx_aclk             (clk),
        .rx_reset            (rx_reset),
        .rx_tvalid           (rx_tvalid),
        .rx_tdata            (rx_tdata),
        .rx_tready           (rx_tready),
        .write_enable        (write_enable),
        .write_pointer       (write_pointer),
        .write_data          (write_data),
        .read_pointer_synced (rps)
    );

    // Input history per cycle; cycle n's inputs are those sampled at the edge closing it.
    int            cyc = 0;
    bit            rst_h [MAXC];
    bit            acc_h [MAXC];
    int            rps_h [MAXC];
    int            pre   [MAXC];
    int            lr_h  [MAXC];
    logic [DW-1:0] sb_q  [$];
    int            stream_log [$];
    bit            stream_log_on = 1'b0;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Pointer = transfers accepted since the last reset, visible two cycles after acceptance.
    function automatic int exp_wp(input int n);
        int l;
        if (n < 2) return 0;
        l = lr_h[n-1];
        if (l < 0 || l == n - 1) return 0;
        return (pre[n-2] - pre[l]) % (1 << AW);
    endfunction

    function automatic bit exp_we(input int n);
        if (n < 1) return 1'b0;
        return !rst_h[n-1] && acc_h[n-1];
    endfunction

    function automatic int exp_diff(input int n);
        if (n < 2 || rst_h[n-1]) return 0;
        return (exp_wp(n-1) - rps_h[n-1]) & ((1 << AW) - 1);
    endfunction

    function automatic bit exp_tready(input int n);
        if (n < 2 || rst_h[n-1]) return 1'b0;
        return exp_diff(n-1) <= (1 << AW) - 5;
    endfunction

    always @(posedge clk) begin
        if (cyc < MAXC) begin
            rst_h[cyc] = rx_reset;
            acc_h[cyc] = rx_tvalid && exp_tready(cyc);
            rps_h[cyc] = int'(rps);
            pre[cyc]   = (cyc > 0 ? pre[cyc-1] : 0) + int'(acc_h[cyc]);
            lr_h[cyc]  = rx_reset ? cyc : (cyc > 0 ? lr_h[cyc-1] : -1);
            if (acc_h[cyc] && !rx_reset) sb_q.push_back(rx_tdata);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int n;
        logic [DW-1:0] d;
        n = cyc;
        if (n >= 2 && n < MAXC) begin
            check("write_enable", write_enable, exp_we(n));
            check("write_pointer", write_pointer, exp_wp(n));
            if (n >= 3) check("rx_tready", rx_tready, exp_tready(n));
            if (exp_we(n)) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_underrun", 1, 0);
                end else begin
                    d = sb_q.pop_front();
                    check("write_data", write_data, d);
                end
            end
            if (stream_log_on && write_enable === 1'b1) stream_log.push_back(int'(write_data));
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rx_reset  = 1'b1;
        rx_tvalid = 1'b0;
        rps       = '0;
        repeat (3) tick;
        rx_reset = 1'b0;
        tick;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int d;
        int stalls;
        int guard;
        int mism;
        bit seen;

        rx_reset  = 1'b1;
        rx_tvalid = 1'b0;
        rx_tdata  = '0;
        rps       = '0;

        // Reset release
        tick;
        tick;
        check("rst_tready", rx_tready, 0);
        check("rst_we", write_enable, 0);
        check("rst_wp", write_pointer, 0);
        tick;
        rx_reset = 1'b0;
        tick;
        check("first_ready", rx_tready, 1);

        // Single write
        rx_tvalid = 1'b1;
        rx_tdata  = 8'hA5;
        tick;
        rx_tvalid = 1'b0;
        check("single_we", write_enable, 1);
        check("single_data", write_data, 8'hA5);
        tick;
        check("single_we_once", write_enable, 0);
        check("single_wp", write_pointer, 1);
        repeat (4) tick;

        // Fill with the read pointer parked at 0
        do_reset;
        rx_tvalid = 1'b1;
        cnt = 0;
        d   = 8'h10;
        for (int i = 0; i < 20; i++) begin
            rx_tdata = 8'(d);
            if (exp_tready(cyc)) d++;
            tick;
            if (write_enable === 1'b1) cnt++;
        end
        check("fill_count", cnt, 7);
        check("fill_wp", write_pointer, 7);
        check("fill_tready", rx_tready, 0);

        // Drain four entries and refill across the pointer wrap
        rps = 3'd4;
        tick;
        check("drain_wait", rx_tready, 0);
        tick;
        check("drain_ready", rx_tready, 1);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            rx_tdata = 8'(d);
            if (exp_tready(cyc)) d++;
            tick;
            if (write_enable === 1'b1) cnt++;
        end
        check("refill_count", cnt, 4);
        check("refill_wp", write_pointer, 3);
        rx_tvalid = 1'b0;
        repeat (3) tick;

        // Streaming with the read pointer trailing by two cycles
        do_reset;
        stream_log_on = 1'b1;
        d      = 0;
        stalls = 0;
        guard  = 0;
        while (d < 100 && guard < 400) begin
            rps       = AW'(exp_wp(cyc - 2));
            rx_tvalid = 1'b1;
            rx_tdata  = 8'(d);
            if (d > 0 && rx_tready !== 1'b1) stalls++;
            if (exp_tready(cyc)) d++;
            tick;
            guard++;
        end
        check("stream_done", d, 100);
        rx_tvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rps = AW'(exp_wp(cyc - 2));
            tick;
        end
        stream_log_on = 1'b0;
        check("stream_stalls", stalls, 0);
        check("stream_count", stream_log.size(), 100);
        mism = 0;
        for (int i = 0; i < stream_log.size(); i++) begin
            if (stream_log[i] != i) mism++;
        end
        check("stream_order", mism, 0);

        // Reset while a write is in flight
        rx_tvalid = 1'b1;
        rx_tdata  = 8'h3C;
        seen      = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            rps = AW'(exp_wp(cyc - 2));
            tick;
            if (write_enable === 1'b1) seen = 1'b1;
        end
        check("mid_we_seen", seen, 1);
        rx_reset = 1'b1;
        tick;
        check("mid_we", write_enable, 0);
        check("mid_wp", write_pointer, 0);
        check("mid_tready", rx_tready, 0);
        rx_tvalid = 1'b0;
        tick;
        rx_reset = 1'b0;
        repeat (3) tick;
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
